// File: rtl/alu_muldiv.sv
// Iterative RV32M-style multiply/divide unit with valid/ready handshakes on both sides.
// Define ALU_MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               negRes_q, negRes_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               isDiv, signedA, signedB, negA, negB;
    logic [WIDTH-1:0]   magA, magB;
    logic               accept, divZero, divOvf;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divGe;
    logic [WIDTH-1:0]   divSub;
    logic [2*WIDTH-1:0] prod, prodFix;
    logic [WIDTH-1:0]   divVal, divFix, fixRes;
`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd, fastFix;
    logic [WIDTH-1:0]   fastRes;
`endif

    assign isDiv   = op[2];
    assign signedA = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    assign signedB = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign negA    = signedA & A[WIDTH-1];
    assign negB    = signedB & B[WIDTH-1];
    assign magA    = negA ? -A : A;
    assign magB    = negB ? -B : B;

    assign accept  = in_valid & (state_q == IDLE) & ~flush;
    assign divZero = isDiv & (B == '0);
    assign divOvf  = isDiv & ~op[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);

    // One shift-add step: hi accumulates, lo holds the multiplier and collects product low bits.
    assign mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    // One restoring-division step: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign divShift = {hi_q, lo_q[WIDTH-1]};
    assign divGe    = divShift >= {1'b0, mcand_q};
    assign divSub   = divShift[WIDTH-1:0] - mcand_q;

    assign prod    = {hi_q, lo_q};
    assign prodFix = negRes_q ? -prod : prod;
    assign divVal  = op_q[1] ? hi_q : lo_q;
    assign divFix  = negRes_q ? -divVal : divVal;
    assign fixRes  = op_q[2] ? divFix
                   : ((op_q[1:0] == 2'b00) ? prodFix[WIDTH-1:0] : prodFix[2*WIDTH-1:WIDTH]);

`ifdef ALU_MULDIV_FAST_MUL_EN
    assign fastProd = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
    assign fastFix  = (negA ^ negB) ? -fastProd : fastProd;
    assign fastRes  = (op[1:0] == 2'b00) ? fastFix[WIDTH-1:0] : fastFix[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        negRes_d = negRes_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = op;
                    cnt_d    = CW'(WIDTH);
                    hi_d     = '0;
                    lo_d     = isDiv ? magA : magB;
                    mcand_d  = isDiv ? magB : magA;
                    // Remainder follows the dividend's sign; everything else follows the operand signs' XOR.
                    negRes_d = (isDiv & op[1]) ? negA : (negA ^ negB);
                    if (divZero) begin
                        result_d = op[1] ? A : '1;
                        state_d  = DONE;
                    end else if (divOvf) begin
                        result_d = op[1] ? '0 : A;
                        state_d  = DONE;
`ifdef ALU_MULDIV_FAST_MUL_EN
                    end else if (!isDiv) begin
                        result_d = fastRes;
                        state_d  = DONE;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q[2]) begin
                    hi_d = divGe ? divSub : divShift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], divGe};
                end else begin
                    hi_d = mulSum[WIDTH:1];
                    lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fixRes;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            negRes_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            negRes_q <= negRes_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed scoreboard bench for alu_muldiv (WIDTH=32): results, latency, hold, flush and reset.
module tb_alu_muldiv;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] A, B, result;

    int   checkCount = 0;
    int   failCount  = 0;
    exp_t expQ[$];
    logic [WIDTH-1:0] lastRes;

`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif

    alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency is the number of clock edges after the accept edge at which out_valid is first high.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] er, input int lat, input string tag);
        exp_t e;
        int   waitCycles = 0;
        @(negedge clk);
        while (!in_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        op = o; A = a; B = b; in_valid = 1'b1;
        e.res = er; e.lat = lat; e.tag = tag;
        expQ.push_back(e);
        lastRes = er;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic checkOutput(input bit handshake);
        exp_t e;
        int   cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 100);
        e = expQ.pop_front();
        check({e.tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({e.tag, " latency"}, 64'(cycles - 1), 64'(e.lat));
        check({e.tag, " result"}, 64'(result), 64'(e.res));
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check({e.tag, " released"}, {62'd0, out_valid, in_ready}, 64'd1);
        end
    endtask

    initial begin
        int validSeen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; A = '0; B = '0; lastRes = '0;
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "MUL");
        checkOutput(1);
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "MULHU");
        checkOutput(1);
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "MULH");
        checkOutput(1);
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT, "MULHSU");
        checkOutput(1);
        applyStimulus(3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, MUL_LAT, "MULH neg*pos");
        checkOutput(1);
        applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, WIDTH + 1, "DIV");
        checkOutput(1);
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, WIDTH + 1, "REM");
        checkOutput(1);
        applyStimulus(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, WIDTH + 1, "DIV pos/neg");
        checkOutput(1);
        applyStimulus(3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, WIDTH + 1, "REM pos/neg");
        checkOutput(1);
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, WIDTH + 1, "DIVU");
        checkOutput(1);
        applyStimulus(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "DIVU by zero");
        checkOutput(1);
        applyStimulus(3'b110, 32'd5, 32'd0, 32'd5, 0, "REM by zero");
        checkOutput(1);
        applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "DIV overflow");
        checkOutput(1);
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, "REM overflow");
        checkOutput(1);

        // Result must stay put while the consumer stalls.
        applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, WIDTH + 1, "REMU");
        checkOutput(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold state", {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, 32'd2});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("hold released", {62'd0, out_valid, in_ready}, 64'd1);

        // Flush mid-CALC with a competing request that must not be accepted.
        @(negedge clk);
        op = 3'b101; A = 32'd100; B = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'b000; A = 32'd3; B = 32'd3;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush result kept", 64'(result), 64'(lastRes));
        validSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) validSeen++;
        end
        check("flush stays idle", 64'(validSeen), 64'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        op = 3'b100; A = 32'hFFFFFFF9; B = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset outputs", {31'd0, out_valid, in_ready, result}, {31'd0, 1'b0, 1'b1, 32'd0});
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'b000, 32'd12345, 32'd1000, 32'd12345000, MUL_LAT, "MUL after reset");
        checkOutput(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
